// File: rtl/khani_sort_pkg.sv
// khani_sort_pkg: shared state encoding, counter sizing and default sizes for the KhaniSort frame controller
package khani_sort_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SORT  = 2'd2,
      DRAIN = 2'd3
   } ks_state_t;

   localparam int KS_N_DEF     = 6;
   localparam int KS_WIDTH_DEF = 8;

   // Width of the load/drain counters; a 2-element frame still needs one bit
   function automatic int ks_cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/khani_sort.sv
// khani_sort: combinational KhaniSort network, ascending order, element 0 is the smallest
module khani_sort #(
   parameter int N     = 6,
   parameter int WIDTH = 8
) (
   input  logic [N-1:0][WIDTH-1:0] din,
   output logic [N-1:0][WIDTH-1:0] dout
);

   logic [N-1:0][WIDTH-1:0] v;
   logic [WIDTH-1:0]        t;

   // Fully unrolled exchange network; equal values are left in place so duplicates pass through untouched
   always_comb begin
      v = din;
      t = '0;
      for (int i = 0; i < N - 1; i++)
         for (int j = 0; j < N - 1 - i; j++)
            if (v[j] > v[j+1]) begin
               t      = v[j];
               v[j]   = v[j+1];
               v[j+1] = t;
            end
      dout = v;
   end

endmodule

// File: rtl/khani_sort_ctrl.sv
// khani_sort_ctrl: collects N stream elements, sorts them with one KhaniSort and replays the sorted frame;
// define KSORT_PIPE_EN to register the sorter input (SORT then lasts 2 cycles)
module khani_sort_ctrl
   import khani_sort_pkg::*;
#(
   parameter int N     = KS_N_DEF,
   parameter int WIDTH = KS_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy
);

   localparam int            CW   = ks_cnt_w(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   ks_state_t               state, state_nx;
   logic [CW-1:0]           cnt, idx;
   logic [N-1:0][WIDTH-1:0] ld_buf, res_buf, srt_in, srt_out;
   logic                    flush_eff, in_fire, out_fire, sort_done;

   assign in_ready  = (state == IDLE) || (state == LOAD);
   assign out_valid = (state == DRAIN);
   assign out_data  = out_valid ? res_buf[idx] : '0;
   assign out_last  = out_valid && (idx == LAST);
   assign busy      = (state != IDLE);

   // flush only matters once a frame is in progress, and it beats any same-cycle handshake
   assign flush_eff = flush && (state != IDLE);
   assign in_fire   = in_valid && in_ready && !flush_eff;
   assign out_fire  = out_valid && out_ready && !flush_eff;

`ifdef KSORT_PIPE_EN
   logic                    ph;
   logic [N-1:0][WIDTH-1:0] pipe_q;

   // First SORT cycle snapshots the load buffer, second one captures the sorter result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph     <= 1'b0;
         pipe_q <= '0;
      end else begin
         ph <= (state == SORT) && !ph && !flush_eff;
         if ((state == SORT) && !ph) pipe_q <= ld_buf;
      end
   end

   assign srt_in    = pipe_q;
   assign sort_done = (state == SORT) && ph;
`else
   assign srt_in    = ld_buf;
   assign sort_done = (state == SORT);
`endif

   khani_sort #(.N(N), .WIDTH(WIDTH)) u_sort (
      .din  (srt_in),
      .dout (srt_out)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state: one frame at a time, load -> sort -> drain
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_fire) state_nx = LOAD;
         LOAD:    if (in_fire && (cnt == LAST)) state_nx = SORT;
         SORT:    if (sort_done) state_nx = DRAIN;
         DRAIN:   if (out_fire && (idx == LAST)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (flush_eff) state_nx = IDLE;
   end

   // Load and drain counters return to 0 at the end of their phase, so they never pass N-1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (flush_eff) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         if (in_fire)  cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
         if (out_fire) idx <= (idx == LAST) ? '0 : idx + CW'(1);
      end
   end

   // Load buffer fills in arrival order; result buffer holds the sorted frame during drain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_buf  <= '0;
         res_buf <= '0;
      end else begin
         if (in_fire) ld_buf[cnt] <= in_data;
         if (sort_done && !flush_eff) res_buf <= srt_out;
      end
   end

endmodule
